trig_out_prescaler: RTL and testbench

//  Downstream stage of the MUSE PID trigger top. Consumes the 7 trigger lines
//  (e/mu/pi up, e/mu/pi down, OR) and gives each channel a programmable 1-of-N

---
 rtl/trig_out_prescaler.sv | 221 ++++++++++++++++++++++
 tb/tb_trig_out_prescaler.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_out_prescaler.sv
// trig_out_prescaler
// Per-channel trigger conditioning: input synchroniser and rising-edge detect,
// programmable 1-of-N prescaler, fixed-width output pulse stretcher, and
// saturating raw/accepted/lost scalers. Everything is reachable over the
// addr/data/rd/wr/ack slow-control bus.
module trig_out_prescaler #(
    parameter int NCH     = 7,
    parameter int PS_W    = 16,
    parameter int CNT_W   = 32,
    parameter int STRETCH = 4
) (
    input  logic             clk_100_i,
    input  logic             reset_i,
    input  logic [NCH-1:0]   trig_in,
    output logic [NCH-1:0]   trig_out,
    input  logic [15:0]      addr,
    input  logic [31:0]      data,
    input  logic             wr,
    input  logic             rd,
    output logic [31:0]      rdata,
    output logic             ack,
    output logic             unknown
);

    localparam int              TW           = $clog2(STRETCH + 1);
    localparam logic [TW-1:0]   STRETCH_LOAD = TW'(STRETCH);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [31:0]     ID_VALUE     = 32'h4D505053;

    // Input conditioning
    logic [NCH-1:0] sync1_reg;
    logic [NCH-1:0] sync2_reg;
    logic [NCH-1:0] sync3_reg;
    logic [NCH-1:0] edge_det;

    // Configuration
    logic             gen_reg;
    logic [NCH-1:0]   cen_reg;
    logic [PS_W-1:0]  ps_reg [NCH];

    // Bus
    logic [31:0]      rdata_reg;
    logic [31:0]      rdata_next;
    logic             ack_reg;
    logic             unknown_reg;
    logic             addr_hit;
    logic             ctrl_wr;
    logic             clr;
    logic [NCH-1:0]   ps_wr;

    // Per-channel scaler read views, zero-extended to the bus width
    logic [NCH-1:0][31:0] raw_rd;
    logic [NCH-1:0][31:0] acc_rd;
    logic [NCH-1:0][31:0] lost_rd;

    // Upper write-data bits have no destination in any register
    logic unused_data_bits;
    assign unused_data_bits = ^data[31:PS_W];

    // Two-flop synchroniser plus one extra stage for rising-edge detection
    always_ff @(posedge clk_100_i) begin
        if (reset_i) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            sync3_reg <= '0;
        end else begin
            sync1_reg <= trig_in;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
        end
    end

    assign edge_det = sync2_reg & ~sync3_reg;

    // Address decode, read-data mux and write-select generation
    always_comb begin
        rdata_next = '0;
        addr_hit   = 1'b0;
        ps_wr      = '0;
        ctrl_wr    = wr && (addr == 16'h0000);
        clr        = ctrl_wr && data[1];
        if (addr == 16'h0000) begin
            addr_hit   = 1'b1;
            rdata_next = 32'({cen_reg, 1'b0, gen_reg});
        end
        if (addr == 16'h00FF) begin
            addr_hit   = 1'b1;
            rdata_next = ID_VALUE;
        end
        for (int i = 0; i < NCH; i++) begin
            if (addr == 16'h0010 + 16'(i)) begin
                addr_hit   = 1'b1;
                rdata_next = 32'(ps_reg[i]);
                ps_wr[i]   = wr;
            end
            if (addr == 16'h0020 + 16'(i)) begin
                addr_hit   = 1'b1;
                rdata_next = raw_rd[i];
            end
            if (addr == 16'h0030 + 16'(i)) begin
                addr_hit   = 1'b1;
                rdata_next = acc_rd[i];
            end
            if (addr == 16'h0040 + 16'(i)) begin
                addr_hit   = 1'b1;
                rdata_next = lost_rd[i];
            end
        end
    end

    // Bus response: one-cycle ack or unknown; rdata only for a pure read
    always_ff @(posedge clk_100_i) begin
        if (reset_i) begin
            ack_reg     <= 1'b0;
            unknown_reg <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            ack_reg     <= (rd || wr) && addr_hit;
            unknown_reg <= (rd || wr) && !addr_hit;
            rdata_reg   <= (rd && !wr && addr_hit) ? rdata_next : '0;
        end
    end

    assign ack     = ack_reg;
    assign unknown = unknown_reg;
    assign rdata   = rdata_reg;

    // Global and per-channel enables; CLR is a strobe and is never stored
    always_ff @(posedge clk_100_i) begin
        if (reset_i) begin
            gen_reg <= 1'b1;
            cen_reg <= '1;
        end else if (ctrl_wr) begin
            gen_reg <= data[0];
            cen_reg <= data[NCH+1:2];
        end
    end

    // Prescale factors
    always_ff @(posedge clk_100_i) begin
        if (reset_i) begin
            for (int i = 0; i < NCH; i++) begin
                ps_reg[i] <= PS_W'(1);
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ps_wr[i]) begin
                    ps_reg[i] <= data[PS_W-1:0];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [PS_W-1:0]  pcnt_reg;
        logic [PS_W-1:0]  ps_last;
        logic [TW-1:0]    timer_reg;
        logic [CNT_W-1:0] raw_reg;
        logic [CNT_W-1:0] acc_reg;
        logic [CNT_W-1:0] lost_reg;
        logic             counted;
        logic             fire;
        logic             accept;
        logic             drop;

        // PS=0 is treated like PS=1, so the terminal count is zero in both cases
        assign ps_last = (ps_reg[gi] == '0) ? '0 : ps_reg[gi] - PS_W'(1);
        // A clear or a prescale rewrite in the same cycle takes the edge out of the prescaler
        assign counted = edge_det[gi] && gen_reg && cen_reg[gi] && !clr && !ps_wr[gi];
        assign fire    = counted && (pcnt_reg >= ps_last);
        assign accept  = fire && (timer_reg == '0);
        assign drop    = fire && (timer_reg != '0);

        // Prescale counter: counts enabled edges, wraps to zero on a fire
        always_ff @(posedge clk_100_i) begin
            if (reset_i) begin
                pcnt_reg <= '0;
            end else if (clr || ps_wr[gi]) begin
                pcnt_reg <= '0;
            end else if (counted) begin
                pcnt_reg <= fire ? '0 : pcnt_reg + PS_W'(1);
            end
        end

        // Stretch timer: loaded by an accepted fire, otherwise runs down to zero
        always_ff @(posedge clk_100_i) begin
            if (reset_i) begin
                timer_reg <= '0;
            end else if (accept) begin
                timer_reg <= STRETCH_LOAD;
            end else if (timer_reg != '0) begin
                timer_reg <= timer_reg - TW'(1);
            end
        end

        // Saturating scalers; CLR beats any same-cycle increment
        always_ff @(posedge clk_100_i) begin
            if (reset_i || clr) begin
                raw_reg  <= '0;
                acc_reg  <= '0;
                lost_reg <= '0;
            end else begin
                if (edge_det[gi] && raw_reg != CNT_MAX) begin
                    raw_reg <= raw_reg + CNT_W'(1);
                end
                if (accept && acc_reg != CNT_MAX) begin
                    acc_reg <= acc_reg + CNT_W'(1);
                end
                if (drop && lost_reg != CNT_MAX) begin
                    lost_reg <= lost_reg + CNT_W'(1);
                end
            end
        end

        assign trig_out[gi] = (timer_reg != '0);
        assign raw_rd[gi]   = 32'(raw_reg);
        assign acc_rd[gi]   = 32'(acc_reg);
        assign lost_rd[gi]  = 32'(lost_reg);
    end

endmodule

// File: tb/tb_trig_out_prescaler.sv
// tb_trig_out_prescaler
// Directed scenarios plus a randomized phase, all checked every cycle against a
// behavioural model of the prescaler/stretcher/scaler/bus rules, with a few
// literal expectations pinning the model. Scalers are built narrow (8 bits)
// so that saturation is reachable in a short run.
module tb_trig_out_prescaler;

    localparam int NCH   = 7;
    localparam int PS_W  = 16;
    localparam int CNT_W = 8;
    localparam int S     = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [31:0] ID_VALUE = 32'h4D505053;

    logic             clk_100_i = 1'b0;
    logic             reset_i;
    logic [NCH-1:0]   trig_in;
    logic [NCH-1:0]   trig_out;
    logic [15:0]      addr;
    logic [31:0]      data;
    logic             wr;
    logic             rd;
    logic [31:0]      rdata;
    logic             ack;
    logic             unknown;

    int n_vec = 0;
    int n_err = 0;

    trig_out_prescaler #(
        .NCH(NCH), .PS_W(PS_W), .CNT_W(CNT_W), .STRETCH(S)
    ) dut (
        .clk_100_i(clk_100_i), .reset_i(reset_i), .trig_in(trig_in), .trig_out(trig_out),
        .addr(addr), .data(data), .wr(wr), .rd(rd),
        .rdata(rdata), .ack(ack), .unknown(unknown)
    );

    always #5 clk_100_i = ~clk_100_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit               model_valid = 1'b0;
    longint           cyc = 0;
    bit               m_gen;
    bit [NCH-1:0]     m_cen;
    int unsigned      m_ps   [NCH];
    int unsigned      m_raw  [NCH];
    int unsigned      m_acc  [NCH];
    int unsigned      m_lost [NCH];
    int unsigned      m_pcnt [NCH];   // enabled edges seen since the last fire
    longint           m_la   [NCH];   // cycle of the last accepted fire
    bit               m_has  [NCH];
    bit [NCH-1:0]     m_hist [3];     // trig_in samples at cycles t-1, t-2, t-3
    bit [NCH-1:0]     m_out;
    bit               m_ack, m_unk;
    logic [31:0]      m_rdata;
    bit [NCH-1:0]     mv_edges;
    logic [31:0]      mv_val;
    bit               mv_hit, mv_clr, mv_wctrl, mv_psw;
    int unsigned      mv_need;

    function automatic int unsigned sat(input int unsigned v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a, output bit hit);
        int unsigned lo, hi;
        hit = 1'b1;
        lo = int'(a[3:0]);
        hi = int'(a[15:4]);
        if (a == 16'h0000) return 32'({m_cen, 1'b0, m_gen});
        if (a == 16'h00FF) return ID_VALUE;
        if (lo < NCH) begin
            case (hi)
                1: return 32'(m_ps[lo] & 32'h0000FFFF);
                2: return 32'(m_raw[lo]);
                3: return 32'(m_acc[lo]);
                4: return 32'(m_lost[lo]);
                default: ;
            endcase
        end
        hit = 1'b0;
        return 32'h0;
    endfunction

    always @(posedge clk_100_i) begin
        cyc++;
        if (reset_i) begin
            model_valid = 1'b1;
            m_gen = 1'b1;
            m_cen = '1;
            for (int i = 0; i < NCH; i++) begin
                m_ps[i] = 1; m_raw[i] = 0; m_acc[i] = 0; m_lost[i] = 0;
                m_pcnt[i] = 0; m_has[i] = 1'b0; m_la[i] = 0;
            end
            for (int j = 0; j < 3; j++) m_hist[j] = '0;
            m_ack = 1'b0; m_unk = 1'b0; m_rdata = '0;
        end else begin
            mv_edges = m_hist[1] & ~m_hist[2];
            mv_val   = model_read(addr, mv_hit);
            m_ack    = (rd || wr) && mv_hit;
            m_unk    = (rd || wr) && !mv_hit;
            m_rdata  = (rd && !wr && mv_hit) ? mv_val : 32'h0;
            mv_wctrl = wr && (addr == 16'h0000);
            mv_clr   = mv_wctrl && data[1];
            for (int i = 0; i < NCH; i++) begin
                mv_psw = wr && (addr == 16'h0010 + 16'(i));
                if (mv_clr) begin
                    m_raw[i] = 0; m_acc[i] = 0; m_lost[i] = 0; m_pcnt[i] = 0;
                end else begin
                    if (mv_edges[i]) m_raw[i] = sat(m_raw[i]);
                    if (mv_psw) begin
                        m_pcnt[i] = 0;
                    end else if (mv_edges[i] && m_gen && m_cen[i]) begin
                        mv_need = (m_ps[i] == 0) ? 1 : m_ps[i];
                        if (m_pcnt[i] + 1 >= mv_need) begin
                            m_pcnt[i] = 0;
                            if (m_has[i] && cyc <= m_la[i] + S) begin
                                m_lost[i] = sat(m_lost[i]);
                            end else begin
                                m_acc[i] = sat(m_acc[i]);
                                m_has[i] = 1'b1;
                                m_la[i]  = cyc;
                            end
                        end else begin
                            m_pcnt[i] = m_pcnt[i] + 1;
                        end
                    end
                end
                if (mv_psw) m_ps[i] = int'(data[PS_W-1:0]);
            end
            if (mv_wctrl) begin
                m_gen = data[0];
                m_cen = data[NCH+1:2];
            end
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = trig_in;
        end
        for (int i = 0; i < NCH; i++) begin
            m_out[i] = m_has[i] && (cyc <= m_la[i] + S - 1);
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk_100_i) begin
        if (model_valid) begin
            check("trig_out", 32'(trig_out), 32'(m_out));
            check("ack", 32'(ack), 32'(m_ack));
            check("unknown", 32'(unknown), 32'(m_unk));
            check("rdata", rdata, m_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic        got_ack, got_unk;
    logic [31:0] got_rdata;

    // Called at a falling edge; returns one falling edge later with the response
    task automatic bus(input bit t_w, input bit t_r, input logic [15:0] t_a, input logic [31:0] t_d);
        wr = t_w; rd = t_r; addr = t_a; data = t_d;
        @(negedge clk_100_i);
        got_ack = ack; got_unk = unknown; got_rdata = rdata;
        wr = 1'b0; rd = 1'b0;
        $display("bus wr=%0d rd=%0d addr=%h data=%h -> ack=%0d unknown=%0d rdata=%h",
                 t_w, t_r, t_a, t_d, got_ack, got_unk, got_rdata);
    endtask

    task automatic rd_check(input logic [15:0] a, input logic [31:0] exp_v, input string name);
        bus(1'b0, 1'b1, a, 32'h0);
        check({name, "_data"}, got_rdata, exp_v);
        check({name, "_ack"}, 32'(got_ack), 32'd1);
    endtask

    int  cnt, run, max_run;
    bit  prev;
    bit  seen;
    logic [15:0] ra;
    logic [31:0] rdv;

    initial begin
        trig_in = '0; wr = 1'b0; rd = 1'b0; addr = '0; data = '0; reset_i = 1'b1;
        repeat (3) @(negedge clk_100_i);
        reset_i = 1'b0;

        // Reset state
        check("reset_trig_out", 32'(trig_out), 32'd0);
        check("reset_ack", 32'(ack), 32'd0);
        rd_check(16'h0000, 32'h000001FD, "ctrl_reset");
        rd_check(16'h0010, 32'd1, "ps0_reset");
        rd_check(16'h0020, 32'd0, "raw0_reset");

        // Single pulse on ch0: four cycles of output
        trig_in[0] = 1'b1;
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk_100_i);
            if (k == 2) trig_in[0] = 1'b0;
            if (trig_out[0]) cnt++;
        end
        check("t1_width", 32'(cnt), 32'd4);
        rd_check(16'h0020, 32'd1, "t1_raw0");
        rd_check(16'h0030, 32'd1, "t1_acc0");

        // 1-of-3 prescale on ch2
        bus(1'b1, 1'b0, 16'h0012, 32'd3);
        cnt = 0; prev = 1'b0;
        for (int p = 0; p < 9; p++) begin
            trig_in[2] = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk_100_i);
                trig_in[2] = 1'b0;
                if (trig_out[2] && !prev) cnt++;
                prev = trig_out[2];
            end
        end
        check("t2_pulses", 32'(cnt), 32'd3);
        rd_check(16'h0022, 32'd9, "t2_raw2");
        rd_check(16'h0032, 32'd3, "t2_acc2");

        // Edges every 2 cycles on ch1: overlapping fires dropped
        run = 0; max_run = 0;
        for (int k = 0; k < 24; k++) begin
            trig_in[1] = (k < 12) && (k % 2 == 0);
            @(negedge clk_100_i);
            run = trig_out[1] ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        check("t3_max_width", 32'(max_run), 32'd4);
        rd_check(16'h0021, 32'd6, "t3_raw1");
        rd_check(16'h0031, 32'd2, "t3_acc1");
        rd_check(16'h0041, 32'd4, "t3_lost1");

        // CLR on the same cycle as a ch3 edge, then GEN=0
        trig_in[3] = 1'b1;
        @(negedge clk_100_i);
        trig_in[3] = 1'b0;
        repeat (8) @(negedge clk_100_i);
        rd_check(16'h0023, 32'd1, "t4_raw3_pre");
        trig_in[3] = 1'b1;
        @(negedge clk_100_i);
        @(negedge clk_100_i);
        bus(1'b1, 1'b0, 16'h0000, 32'h00000002);
        trig_in[3] = 1'b0;
        repeat (4) @(negedge clk_100_i);
        rd_check(16'h0023, 32'd0, "t4_raw3_clr");
        rd_check(16'h0020, 32'd0, "t4_raw0_clr");
        rd_check(16'h0032, 32'd0, "t4_acc2_clr");
        rd_check(16'h0041, 32'd0, "t4_lost1_clr");
        rd_check(16'h0000, 32'd0, "t4_ctrl");
        cnt = 0;
        for (int p = 0; p < 2; p++) begin
            trig_in[3] = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk_100_i);
                trig_in[3] = 1'b0;
                if (trig_out != '0) cnt++;
            end
        end
        check("t4_no_output", 32'(cnt), 32'd0);
        rd_check(16'h0023, 32'd2, "t4_raw3_gen0");

        // Bus corner cases
        bus(1'b0, 1'b1, 16'h0077, 32'h0);
        check("t5_unk_flag", 32'(got_unk), 32'd1);
        check("t5_unk_ack", 32'(got_ack), 32'd0);
        bus(1'b0, 1'b1, 16'h0017, 32'h0);
        check("t5_gap_unk", 32'(got_unk), 32'd1);
        rd_check(16'h00FF, ID_VALUE, "t5_id");
        bus(1'b1, 1'b1, 16'h0010, 32'd5);
        check("t5_wrrd_ack", 32'(got_ack), 32'd1);
        check("t5_wrrd_rdata", got_rdata, 32'd0);
        rd_check(16'h0010, 32'd5, "t5_ps0");
        bus(1'b1, 1'b0, 16'h0023, 32'd123);
        check("t5_ro_ack", 32'(got_ack), 32'd1);
        rd_check(16'h0023, 32'd2, "t5_ro_kept");

        // Restore enables and PS0=1, then saturate ch0 scalers
        bus(1'b1, 1'b0, 16'h0000, 32'h000001FD);
        bus(1'b1, 1'b0, 16'h0010, 32'd1);
        for (int p = 0; p < 300; p++) begin
            trig_in[0] = 1'b1;
            @(negedge clk_100_i);
            trig_in[0] = 1'b0;
            repeat (5) @(negedge clk_100_i);
        end
        repeat (6) @(negedge clk_100_i);
        rd_check(16'h0020, CNT_MAX, "t6_raw0_sat");
        rd_check(16'h0030, CNT_MAX, "t6_acc0_sat");

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < NCH; b++) trig_in[b] = ($urandom_range(0, 9) < 3);
            wr = 1'b0; rd = 1'b0;
            if ($urandom_range(0, 9) < 4) begin
                case ($urandom_range(0, 7))
                    0: ra = 16'h0000;
                    1: ra = 16'h0010 + 16'($urandom_range(0, 8));
                    2: ra = 16'h0020 + 16'($urandom_range(0, 7));
                    3: ra = 16'h0030 + 16'($urandom_range(0, 7));
                    4: ra = 16'h0040 + 16'($urandom_range(0, 7));
                    5: ra = 16'h00FF;
                    6: ra = 16'h0077;
                    default: ra = 16'($urandom);
                endcase
                rdv = $urandom;
                if (ra == 16'h0000) begin
                    rdv[0] = ($urandom_range(0, 4) != 0);
                    rdv[1] = ($urandom_range(0, 19) == 0);
                end else if (ra[15:4] == 12'h001) begin
                    rdv = 32'($urandom_range(0, 4));
                end
                wr = ($urandom_range(0, 9) < 3);
                rd = ($urandom_range(0, 9) < 5);
                addr = ra; data = rdv;
                $display("rnd wr=%0d rd=%0d addr=%h data=%h", wr, rd, ra, rdv);
            end
            @(negedge clk_100_i);
        end
        trig_in = '0; wr = 1'b0; rd = 1'b0;
        bus(1'b1, 1'b0, 16'h0000, 32'h000001FD);
        bus(1'b1, 1'b0, 16'h0010, 32'd1);
        repeat (10) @(negedge clk_100_i);

        // Reset in the middle of a stretched pulse, with a read in flight
        trig_in[0] = 1'b1;
        @(negedge clk_100_i);
        trig_in[0] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk_100_i);
            if (trig_out[0]) seen = 1'b1;
        end
        check("t7_pulse_seen", 32'(seen), 32'd1);
        @(negedge clk_100_i);
        reset_i = 1'b1; rd = 1'b1; addr = 16'h00FF;
        @(negedge clk_100_i);
        check("t7_reset_trig_out", 32'(trig_out[0]), 32'd0);
        check("t7_reset_ack", 32'(ack), 32'd0);
        rd = 1'b0; reset_i = 1'b0;
        repeat (3) @(negedge clk_100_i);
        rd_check(16'h0020, 32'd0, "t7_raw0_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
